mem_stage_access_ctrl: RTL
==========================

Name: mem_stage_access_ctrl

Overview:
- MEM-stage data-memory access controller of the 5-stage MIPS pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Converts EX/MEM load/store controls into a req/ack transaction on the data-memory port, handling byte/half/word lanes and load extension.
- Stalls the pipeline while the memory is busy and supplies the formatted load data that MEM/WB captures as read data.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in ACCESS awaiting ack before abort (1..255; counter 8 bits)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_read_i  input  1  load in MEM stage
mem_write_i  input  1  store in MEM stage
size_i  input  2  00 byte, 01 half, 10 word, 11 treated as word
unsigned_i  input  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend
addr_i  input  32  effective address (EX/MEM ALU result)
wdata_i  input  32  store data (rt value)
dmem_req_o  output  1  memory request, held high until ack
dmem_we_o  output  1  1 = write transaction
dmem_addr_o  output  32  word-aligned address {addr_i[31:2],2'b00}
dmem_be_o  output  4  byte enables, little-endian
dmem_wdata_o  output  32  lane-replicated store data
dmem_ack_i  input  1  memory completion, one-cycle pulse
dmem_rdata_i  input  32  read word, valid with ack
read_data_mmry_o  output  32  formatted load data to MEM/WB
stall_o  output  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
misaligned_o  output  1  alignment fault pulse
timeout_o  output  1  one-cycle pulse on aborted access

Behaviour:
- Reset values: state IDLE, dmem_req_o/dmem_we_o 0, dmem_addr_o/dmem_be_o/dmem_wdata_o 0, read_data_mmry_o 0, stall_o 0, misaligned_o 0, timeout_o 0, timeout counter 0.
- Access = mem_read_i | mem_write_i. If both are high, the write wins.
- Misaligned conditions:
  - half with addr_i[0]=1
  - word with addr_i[1:0]!=0
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Aligned access: stall_o=1 combinationally. On the clock edge, register addr/be/wdata/we, set dmem_req_o=1, clear the counter, go to ACCESS.
  - Misaligned access: misaligned_o=1 combinationally that cycle, no request, no stall, read_data_mmry_o<=0, stay in IDLE.
  - No access: stay in IDLE, stall_o=0.
- ACCESS:
  - stall_o=1, and dmem_* outputs are held stable.
  - Ack: dmem_req_o<=0. On a read, read_data_mmry_o<=extracted data. Go to DONE.
  - No ack and counter==TIMEOUT_CYCLES-1: dmem_req_o<=0, timeout_o<=1 for one cycle, read_data_mmry_o<=0, go to DONE.
  - Otherwise the counter increments.
- DONE: stall_o=0 for exactly one cycle so the pipeline advances past the instruction, then unconditionally go to IDLE. This guarantees no re-issue of the same instruction.
- Latency:
  - Zero-wait memory (ack in the first ACCESS cycle): 2 stall cycles; data valid in DONE.
  - N wait cycles: 2+N stall cycles.
- read_data_mmry_o holds its value until the next completed load, misaligned access, or timeout. Stores do not change it.
- Store lanes, with b=addr_i[1:0]:
  - sb: be=1<<b, wdata={4{wdata_i[7:0]}}
  - sh: be=addr_i[1]?1100:0011, wdata={2{wdata_i[15:0]}}
  - sw: be=1111, wdata=wdata_i
- Load extraction: select byte b, or half addr_i[1]; sign- or zero-extend per unsigned_i; word passes through.
- For reads, dmem_be_o is asserted as for a store of the same size.
- dmem_ack_i while in IDLE or DONE is ignored.
- Reset asserted mid-ACCESS: immediate return to reset values. The memory must tolerate a dropped request.

Test Plan:
- lw addr 0x100, ack in first ACCESS cycle, rdata 0xDEADBEEF -> req high 1 cycle, be 1111, stall 2 cycles, read_data_mmry_o=0xDEADBEEF in DONE.
- lb addr 0x103, rdata 0x80FF1234, unsigned_i=0 -> be 1000, read_data_mmry_o=0xFFFFFF80; with unsigned_i=1 -> 0x00000080.
- sh addr 0x202, wdata 0x0000ABCD, ack after 3 wait cycles -> addr 0x200, be 1100, dmem_wdata_o 0xABCDABCD, stall 5 cycles, read_data_mmry_o unchanged.
- lw addr 0x101 -> misaligned_o pulse, no req, stall_o 0, read_data_mmry_o=0.
- TIMEOUT_CYCLES=4, load with no ack -> req drops after 4 ACCESS cycles, timeout_o 1-cycle pulse, read data 0, FSM returns to IDLE.
- Reset asserted in the 2nd ACCESS cycle -> req, stall and data outputs 0 immediately; a subsequent load completes normally.

Source files
------------

// File: rtl/mem_stage_access_ctrl_if.sv
// mem_stage_access_ctrl_if: data-memory req/ack bus between the MEM-stage controller and memory
interface mem_stage_access_ctrl_if;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;
   modport master (
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
      input  dmem_ack_i, dmem_rdata_i
   );
   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
      output dmem_ack_i, dmem_rdata_i
   );
endinterface

// File: rtl/mem_stage_access_ctrl.sv
// mem_stage_access_ctrl: MEM-stage load/store controller with lane steering, load extension and pipeline stall
module mem_stage_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mem_read_i,
   input  logic                 mem_write_i,
   input  logic [1:0]           size_i,
   input  logic                 unsigned_i,
   input  logic [31:0]          addr_i,
   input  logic [31:0]          wdata_i,
   mem_stage_access_ctrl_if.master dmem,
   output logic [31:0]          read_data_mmry_o,
   output logic                 stall_o,
   output logic                 misaligned_o,
   output logic                 timeout_o
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_q, req_d, we_q, we_d, to_q, to_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d;
   logic [3:0]  be_q, be_d;
   logic        access, is_byte, is_half, mis;
   logic [3:0]  be_n;
   logic [31:0] wd_n, ld;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   // The pipeline is frozen during the access, so addr_i/size_i/unsigned_i stay valid for lane selection
   always_comb begin
      access  = mem_read_i | mem_write_i;
      is_byte = size_i == 2'b00;
      is_half = size_i == 2'b01;
      mis     = (is_half & addr_i[0]) | (size_i[1] & |addr_i[1:0]);
      be_n    = is_byte ? 4'b0001 << addr_i[1:0] : is_half ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wd_n    = is_byte ? {4{wdata_i[7:0]}} : is_half ? {2{wdata_i[15:0]}} : wdata_i;
      byte_v  = dmem.dmem_rdata_i[{addr_i[1:0], 3'b000} +: 8];
      half_v  = addr_i[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
      ld      = is_byte ? {{24{~unsigned_i & byte_v[7]}}, byte_v} :
                is_half ? {{16{~unsigned_i & half_v[15]}}, half_v} : dmem.dmem_rdata_i;
   end
   // Next-state and stall/fault outputs; DONE gives the pipeline one free cycle so the instruction is never re-issued
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      rd_d         = rd_q;
      to_d         = 1'b0;
      stall_o      = 1'b0;
      misaligned_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (access && mis) begin
               misaligned_o = 1'b1;
               rd_d         = '0;
            end else if (access) begin
               stall_o = 1'b1;
               req_d   = 1'b1;
               we_d    = mem_write_i;
               addr_d  = {addr_i[31:2], 2'b00};
               be_d    = be_n;
               wdata_d = wd_n;
               cnt_d   = '0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            stall_o = 1'b1;
            if (dmem.dmem_ack_i) begin
               req_d   = 1'b0;
               rd_d    = we_q ? rd_q : ld;
               state_d = DONE;
            end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
               req_d   = 1'b0;
               to_d    = 1'b1;
               rd_d    = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // State and registered bus/data outputs; reset drops any in-flight request immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         to_q    <= to_d;
      end
   end
   assign dmem.dmem_req_o   = req_q;
   assign dmem.dmem_we_o    = we_q;
   assign dmem.dmem_addr_o  = addr_q;
   assign dmem.dmem_be_o    = be_q;
   assign dmem.dmem_wdata_o = wdata_q;
   assign read_data_mmry_o  = rd_q;
   assign timeout_o         = to_q;
endmodule
